// File: rtl/smart_mac_pe_v2.sv
// SMART systolic processing element: output- or weight-stationary MAC with
// bypassable SMART bus links and a local K-length reduction sequencer.
module smart_mac_pe_v2 #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ACC_SIZE  = 40,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid_in,
  input  logic [4:0]           cfg_in,
  input  logic                 start_in,
  input  logic [CNT_WIDTH-1:0] k_len_in,
  input  logic [WORD_SIZE-1:0] left_in,
  input  logic [WORD_SIZE-1:0] top_in,
  input  logic [WORD_SIZE-1:0] horizontal_smart_bus_in,
  input  logic [WORD_SIZE-1:0] vertical_smart_bus_in,
  output logic [WORD_SIZE-1:0] right_out,
  output logic [WORD_SIZE-1:0] bottom_out,
  output logic [WORD_SIZE-1:0] horizontal_smart_bus_out,
  output logic [WORD_SIZE-1:0] vertical_smart_bus_out,
  output logic                 acc_valid_out,
  output logic                 busy_out
);

  localparam int unsigned PROD_SIZE = 2 * WORD_SIZE;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [4:0]                  cfg_q, cfg_d;
  logic signed [ACC_SIZE-1:0]  acc_q, acc_d;
  logic signed [WORD_SIZE-1:0] weight_q, weight_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]        right_d, bottom_d;
  logic                        acc_valid_d, busy_d;

  logic signed [WORD_SIZE-1:0] l_op, t_op;
  logic signed [PROD_SIZE-1:0] lt_prod, lw_prod;
  logic signed [ACC_SIZE-1:0]  ws_sum, acc_shr;
  logic                        start_ws;

  // Clamp a wide signed value into the signed WORD_SIZE range.
  function automatic logic [WORD_SIZE-1:0] sat(input logic signed [ACC_SIZE-1:0] v);
    logic [ACC_SIZE-WORD_SIZE:0] hi;
    hi = v[ACC_SIZE-1:WORD_SIZE-1];
    if ((&hi) || !(|hi)) sat = v[WORD_SIZE-1:0];
    else if (v[ACC_SIZE-1]) sat = {1'b1, {(WORD_SIZE-1){1'b0}}};
    else sat = {1'b0, {(WORD_SIZE-1){1'b1}}};
  endfunction

  assign l_op = cfg_q[0] ? horizontal_smart_bus_in : left_in;
  assign t_op = cfg_q[1] ? vertical_smart_bus_in : top_in;

  assign horizontal_smart_bus_out = cfg_q[2] ? right_out : horizontal_smart_bus_in;
  assign vertical_smart_bus_out   = cfg_q[3] ? bottom_out : vertical_smart_bus_in;

  assign lt_prod = PROD_SIZE'(l_op) * PROD_SIZE'(t_op);
  assign lw_prod = PROD_SIZE'(l_op) * PROD_SIZE'(weight_q);
  assign ws_sum  = ACC_SIZE'(t_op) + ACC_SIZE'(lw_prod);
  assign acc_shr = acc_q >>> FRAC_BITS;

  // A config written together with start governs the operation being started.
  assign start_ws = cfg_valid_in ? cfg_in[4] : cfg_q[4];

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    acc_d       = acc_q;
    weight_d    = weight_q;
    cnt_d       = cnt_q;
    right_d     = l_op;
    bottom_d    = t_op;
    acc_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid_in) cfg_d = cfg_in;
        if (start_in) begin
          cnt_d = k_len_in;
          acc_d = '0;
          if (start_ws)                     state_d = LOAD;
          else if (k_len_in == '0)          state_d = DRAIN;
          else                              state_d = RUN;
        end
      end
      LOAD: begin
        weight_d = t_op;
        state_d  = (cnt_q == '0) ? IDLE : RUN;
      end
      RUN: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cfg_q[4]) bottom_d = sat(ws_sum);
        else          acc_d    = acc_q + ACC_SIZE'(lt_prod);
        if (cnt_q == CNT_WIDTH'(1)) state_d = cfg_q[4] ? IDLE : DRAIN;
      end
      DRAIN: begin
        bottom_d    = sat(acc_shr);
        acc_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      acc_q         <= '0;
      weight_q      <= '0;
      cnt_q         <= '0;
      right_out     <= '0;
      bottom_out    <= '0;
      acc_valid_out <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      acc_q         <= acc_d;
      weight_q      <= weight_d;
      cnt_q         <= cnt_d;
      right_out     <= right_d;
      bottom_out    <= bottom_d;
      acc_valid_out <= acc_valid_d;
      busy_out      <= busy_d;
    end
  end

endmodule

// File: doc/smart_mac_pe_v2.md
# smart_mac_pe_v2

Parametrised second-generation SMART processing element for the systolic array. It supports output-stationary (OS) and weight-stationary (WS) dataflow, selected per operation. All four directions can be routed onto or bypassed over the SMART buses, and a local controller sequences a K-length reduction without per-cycle FSM control from the array. Accumulation is wide, and results saturate to WORD_SIZE.

## Interface
- WORD_SIZE, 16: operand, bus and output width (signed two's complement).
- ACC_SIZE, 40: accumulator width; must be ≥ 2*WORD_SIZE.
- FRAC_BITS, 0: arithmetic right shift applied to the accumulator before output saturation.
- CNT_WIDTH, 8: width of the reduction-length counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid_in  in  1  latch cfg_in; honoured only in IDLE.
- cfg_in  in  5  [0] sel_left_smart, [1] sel_top_smart, [2] sel_right_smart, [3] sel_bottom_smart, [4] stat_mode (0 = OS, 1 = WS).
- start_in  in  1  begin an operation; honoured only in IDLE.
- k_len_in  in  CNT_WIDTH  reduction length K, sampled with start_in.
- left_in, top_in  in  WORD_SIZE  neighbour operands.
- horizontal_smart_bus_in, vertical_smart_bus_in  in  WORD_SIZE  SMART bus inputs.
- right_out, bottom_out  out  WORD_SIZE  registered neighbour outputs.
- horizontal_smart_bus_out, vertical_smart_bus_out  out  WORD_SIZE  SMART bus outputs.
- acc_valid_out  out  1  one-cycle strobe: bottom_out carries the OS result.
- busy_out  out  1  high in any state except IDLE.

## Operation
- Operand muxes (combinational):
  - L = sel_left_smart ? horizontal_smart_bus_in : left_in
  - T = sel_top_smart ? vertical_smart_bus_in : top_in
- Bus muxes (combinational):
  - horizontal_smart_bus_out = sel_right_smart ? right_out : horizontal_smart_bus_in
  - vertical_smart_bus_out = sel_bottom_smart ? bottom_out : vertical_smart_bus_in
- Config register: reset value 0 (all direct links, OS mode).
  - Loads when cfg_valid_in=1 and state is IDLE; ignored otherwise.
  - If cfg_valid_in and start_in are both high in IDLE, the new config applies to the operation being started.
- Counter:
  - Loaded with K at start.
  - Decremented once per consumed operand.
  - Leaves RUN when the count reaches 0.
- States:
  - IDLE --start_in--> RUN (OS, K>0), DRAIN (OS, K=0), LOAD (WS).
  - LOAD: weight_reg <= T; go to RUN, or to IDLE if K=0.
  - RUN: one operand per cycle.
    - OS: acc <= acc + L*T.
    - WS: bottom_out <= sat(T + L*weight_reg).
    - After the K-th operand, OS goes to DRAIN and WS goes to IDLE.
  - DRAIN (OS only): bottom_out <= sat(acc >>> FRAC_BITS); acc_valid_out <= 1; go to IDLE.
- Arithmetic:
  - Product is 2*WORD_SIZE signed, sign-extended to ACC_SIZE.
  - The accumulator wraps modulo 2^ACC_SIZE. acc is cleared at start.
  - sat() clamps to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - The WS sum is computed at ACC_SIZE width before saturation.
- Forwarding:
  - right_out <= L every cycle, in every state.
  - bottom_out <= T in every cycle not covered by the WS RUN or DRAIN rules above.
  - acc_valid_out <= 0 except in the DRAIN cycle.
- Reset, including mid-operation, clears:
  - state to IDLE
  - config, acc, weight_reg and counter
  - right_out, bottom_out and acc_valid_out to 0
  - Any in-flight operation is abandoned with no result strobe.

## Timing
- Edge 0 is the edge that samples start_in=1.
- OS:
  - Operands are sampled at edges 1..K.
  - DRAIN occupies the cycle after edge K.
  - The result and acc_valid_out=1 appear after edge K+1, for exactly one cycle.
  - busy_out is high from after edge 0 through edge K+1. A new start is accepted at edge K+2 at the earliest.
- WS:
  - The weight is sampled at edge 1.
  - Partial sums are registered at edges 2..K+1.
  - IDLE is reached after edge K+1. With K=0, IDLE is reached after edge 1.
- Latency:
  - right_out and bottom_out forwarding: 1 cycle.
  - Bus-out muxes: 0 cycles, combinational from the registered outputs.
- start_in or cfg_valid_in while busy: no effect, no error.

## Test plan
- Reset, then cfg=0, start with K=3; L=2,3,4 and T=5,6,7 on edges 1-3 -> after edge 4: bottom_out=56, acc_valid_out=1 for one cycle; busy_out falls at the same time.
- OS saturation (WORD_SIZE=16), K=2, L=T=32767 twice -> bottom_out=32767. Repeat with L=-32768, T=32767 -> bottom_out=-32768.
- WS (cfg[4]=1), K=2: weight T=3 at edge 1; then L=4,T=10 and L=-2,T=1 -> bottom_out=22, then -5. acc_valid_out stays 0 throughout.
- SMART routing, cfg=5'b01111: horizontal_smart_bus_in=9, vertical_smart_bus_in=11, left_in=top_in=0, OS K=1 -> result 99 on bottom_out and on vertical_smart_bus_out; horizontal_smart_bus_out equals right_out=9.
- Boundary cases:
  - OS K=0 -> result 0 with acc_valid_out after edge 1.
  - cfg_valid_in while busy -> ignored; the next operation uses the old config.
  - cfg_valid_in and start_in together in IDLE -> the new mode is used.
- Assert rst during OS RUN (K=5, edge 3) -> all outputs 0 on the next edge, no acc_valid_out, busy_out=0; a fresh start then works normally.
